// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions: control-bundle bit positions and MEM FSM states.
package pipe_pkg;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;
  localparam int REG_WRITE  = 1;
  localparam int MEM_TO_REG = 0;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_state_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM-to-stage and stage-to-WB signal bundle.
// The master drives the EX/MEM side and observes the results; the slave is the stage.
interface mem_wb_stage_if;
  logic [1:0]  W_in;
  logic [1:0]  M_in;
  logic [31:0] ALU_in;
  logic [31:0] RD2_in;
  logic [4:0]  WN_in;
  logic [1:0]  W_out;
  logic [31:0] RD_out;
  logic [31:0] ALU_out;
  logic [4:0]  WN_out;
  logic        stall;

  modport master (output W_in, M_in, ALU_in, RD2_in, WN_in,
                  input  W_out, RD_out, ALU_out, WN_out, stall);
  modport slave  (input  W_in, M_in, ALU_in, RD2_in, WN_in,
                  output W_out, RD_out, ALU_out, WN_out, stall);
endinterface

// File: rtl/mem_wb_stage_data_memory.sv
// Word-addressed data memory: combinational read, synchronous write.
module data_memory #(
  parameter int MEM_WORDS = 256,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [MEM_WORDS];

  // Contents are deliberately left unreset; writes only on enable.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with multi-cycle data-memory access and the MEM/WB register.
// An access occupies LATENCY cycles; all but the last stall upstream and push bubbles.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_wb_stage_if.slave   bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;
  localparam bit MULTI = (LATENCY > 1);

  mem_state_t    state;
  logic [CW-1:0] cnt;
  logic          op, complete, we;
  logic [31:0]   rdata;

  assign op = |bus.M_in;

  // Completing cycle: non-memory op, single-cycle memory, or last BUSY cycle.
  assign complete = !MULTI || (state == IDLE && !op) || (state == BUSY && cnt == '0);

  assign bus.stall = !rst && MULTI &&
                     ((state == IDLE && op) || (state == BUSY && cnt != '0));

  // The illegal 2'b11 encoding still writes, since it carries MemWrite.
  assign we = !rst && complete && bus.M_in[MEM_WRITE];

  data_memory #(.MEM_WORDS(MEM_WORDS)) u_dmem (
    .clk   (clk),
    .we    (we),
    .addr  (bus.ALU_in[AW+1:2]),
    .wdata (bus.RD2_in),
    .rdata (rdata)
  );

  // Access sequencer: IDLE launches a multi-cycle op, BUSY counts down to completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (MULTI) begin
      case (state)
        IDLE: if (op) begin
          state <= BUSY;
          cnt   <= CNT_INIT;
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: capture on completion, otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (rst || !complete) begin
      bus.W_out   <= '0;
      bus.RD_out  <= '0;
      bus.ALU_out <= '0;
      bus.WN_out  <= '0;
    end else begin
      bus.W_out   <= bus.W_in;
      bus.RD_out  <= (bus.M_in == 2'b10) ? rdata : 32'h0;
      bus.ALU_out <= bus.ALU_in;
      bus.WN_out  <= bus.WN_in;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench: four instances cover LATENCY 2, 3, 4 and 1 on shared stimulus;
// instances not under test are held in reset.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst2 = 1'b1, rst3 = 1'b1, rst4 = 1'b1, rst1 = 1'b1;
  logic [1:0]  w = '0, m = '0;
  logic [31:0] alu = '0, rd2 = '0;
  logic [4:0]  wn = '0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if b2 ();
  mem_wb_stage_if b3 ();
  mem_wb_stage_if b4 ();
  mem_wb_stage_if b1 ();

  assign b2.W_in = w; assign b2.M_in = m; assign b2.ALU_in = alu; assign b2.RD2_in = rd2; assign b2.WN_in = wn;
  assign b3.W_in = w; assign b3.M_in = m; assign b3.ALU_in = alu; assign b3.RD2_in = rd2; assign b3.WN_in = wn;
  assign b4.W_in = w; assign b4.M_in = m; assign b4.ALU_in = alu; assign b4.RD2_in = rd2; assign b4.WN_in = wn;
  assign b1.W_in = w; assign b1.M_in = m; assign b1.ALU_in = alu; assign b1.RD2_in = rd2; assign b1.WN_in = wn;

  mem_wb_stage #(.MEM_WORDS(256), .LATENCY(2)) u2 (.clk(clk), .rst(rst2), .bus(b2));
  mem_wb_stage #(.MEM_WORDS(256), .LATENCY(3)) u3 (.clk(clk), .rst(rst3), .bus(b3));
  mem_wb_stage #(.MEM_WORDS(256), .LATENCY(4)) u4 (.clk(clk), .rst(rst4), .bus(b4));
  mem_wb_stage #(.MEM_WORDS(256), .LATENCY(1)) u1 (.clk(clk), .rst(rst1), .bus(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wi, input logic [1:0] mi, input logic [31:0] ai,
                       input logic [31:0] di, input logic [4:0] ni);
    w = wi; m = mi; alu = ai; rd2 = di; wn = ni;
  endtask

  initial begin
    // Reset held two cycles with nonzero inputs.
    drive(2'b11, 2'b10, 32'hFFFF, 32'h1, 5'd7);
    tick(); tick();
    settle();
    chk("rst_stall", 32'(b2.stall), 32'd0);
    chk("rst_W", 32'(b2.W_out), 32'd0);
    chk("rst_RD", b2.RD_out, 32'd0);
    chk("rst_ALU", b2.ALU_out, 32'd0);
    chk("rst_WN", 32'(b2.WN_out), 32'd0);

    // LATENCY=2: ALU op, single cycle, no stall.
    rst2 = 1'b0;
    drive(2'b10, 2'b00, 32'h0000_1234, 32'h0, 5'd5);
    settle();
    chk("alu_stall", 32'(b2.stall), 32'd0);
    tick();
    chk("alu_W", 32'(b2.W_out), 32'd2);
    chk("alu_ALU", b2.ALU_out, 32'h1234);
    chk("alu_WN", 32'(b2.WN_out), 32'd5);
    chk("alu_RD", b2.RD_out, 32'd0);
    // LATENCY=2 store: one stall cycle.
    drive(2'b00, 2'b01, 32'h8, 32'h55, 5'd0);
    settle();
    chk("l2_st_stall", 32'(b2.stall), 32'd1);
    tick();
    chk("l2_st_bubble_ALU", b2.ALU_out, 32'd0);
    chk("l2_st_last_stall", 32'(b2.stall), 32'd0);
    tick();
    chk("l2_st_done_ALU", b2.ALU_out, 32'h8);
    rst2 = 1'b1;

    // LATENCY=3: store then immediate load to the same address.
    rst3 = 1'b0;
    drive(2'b00, 2'b01, 32'h40, 32'hDEADBEEF, 5'd0);
    settle();
    chk("st_stall0", 32'(b3.stall), 32'd1);
    tick();
    chk("st_bubble1_W", 32'(b3.W_out), 32'd0);
    chk("st_stall1", 32'(b3.stall), 32'd1);
    tick();
    chk("st_bubble2_ALU", b3.ALU_out, 32'd0);
    chk("st_stall2", 32'(b3.stall), 32'd0);
    tick();
    chk("st_done_ALU", b3.ALU_out, 32'h40);
    drive(2'b11, 2'b10, 32'h40, 32'h0, 5'd8);
    settle();
    chk("ld_stall0", 32'(b3.stall), 32'd1);
    tick();
    chk("ld_bubble_WN", 32'(b3.WN_out), 32'd0);
    tick();
    chk("ld_stall2", 32'(b3.stall), 32'd0);
    tick();
    chk("ld_RD", b3.RD_out, 32'hDEADBEEF);
    chk("ld_WN", 32'(b3.WN_out), 32'd8);
    chk("ld_W", 32'(b3.W_out), 32'd3);
    // Wrap: 0x403 maps to word 0.
    drive(2'b00, 2'b01, 32'h403, 32'hA5A5A5A5, 5'd0);
    tick(); tick(); tick();
    drive(2'b11, 2'b10, 32'h000, 32'h0, 5'd2);
    tick(); tick(); tick();
    chk("wrap_RD", b3.RD_out, 32'hA5A5A5A5);
    chk("wrap_ALU", b3.ALU_out, 32'h0);
    rst3 = 1'b1;

    // LATENCY=4: preload, then reset in the middle of a store.
    rst4 = 1'b0;
    drive(2'b00, 2'b01, 32'h10, 32'h22222222, 5'd0);
    tick(); tick(); tick(); tick();
    drive(2'b00, 2'b01, 32'h10, 32'h11111111, 5'd0);
    settle();
    chk("mid_stall_a", 32'(b4.stall), 32'd1);
    tick();
    chk("mid_stall_b", 32'(b4.stall), 32'd1);
    rst4 = 1'b1;
    settle();
    chk("mid_rst_stall", 32'(b4.stall), 32'd0);
    tick();
    chk("mid_rst_ALU", b4.ALU_out, 32'd0);
    chk("mid_rst_W", 32'(b4.W_out), 32'd0);
    rst4 = 1'b0;
    drive(2'b11, 2'b10, 32'h10, 32'h0, 5'd3);
    settle();
    chk("mid_ld_stall", 32'(b4.stall), 32'd1);
    tick(); tick(); tick();
    chk("mid_ld_last_stall", 32'(b4.stall), 32'd0);
    tick();
    chk("mid_ld_RD", b4.RD_out, 32'h22222222);
    chk("mid_ld_WN", 32'(b4.WN_out), 32'd3);
    rst4 = 1'b1;

    // LATENCY=1: op every cycle, never stalls.
    rst1 = 1'b0;
    drive(2'b00, 2'b01, 32'h20, 32'h77, 5'd0);
    settle();
    chk("l1_st_stall", 32'(b1.stall), 32'd0);
    tick();
    chk("l1_st_ALU", b1.ALU_out, 32'h20);
    chk("l1_st_RD", b1.RD_out, 32'd0);
    drive(2'b11, 2'b10, 32'h20, 32'h0, 5'd9);
    settle();
    chk("l1_ld_stall", 32'(b1.stall), 32'd0);
    tick();
    chk("l1_ld_RD", b1.RD_out, 32'h77);
    chk("l1_ld_WN", 32'(b1.WN_out), 32'd9);
    drive(2'b10, 2'b00, 32'h99, 32'h0, 5'd4);
    tick();
    chk("l1_alu_ALU", b1.ALU_out, 32'h99);
    chk("l1_alu_RD", b1.RD_out, 32'd0);
    drive(2'b11, 2'b11, 32'h24, 32'hCAFEF00D, 5'd6);
    settle();
    chk("l1_ill_stall", 32'(b1.stall), 32'd0);
    tick();
    chk("l1_ill_RD", b1.RD_out, 32'd0);
    chk("l1_ill_WN", 32'(b1.WN_out), 32'd6);
    drive(2'b11, 2'b10, 32'h24, 32'h0, 5'd1);
    tick();
    chk("l1_ill_readback", b1.RD_out, 32'hCAFEF00D);
    rst1 = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the 5-stage pipeline.
- Consumes the EX/MEM register outputs: write-back controls, memory controls, ALU result, store data and destination register.
- Performs the data-memory access over a parameterised multi-cycle latency and stalls upstream for the duration.
- Registers the write-back bundle into the WB stage.

Parameters:
- MEM_WORDS, 256: data memory depth in 32-bit words; power of two.
- LATENCY, 2: cycles per memory access, >= 1. A value of 1 means no stall.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- W_in  input  2  write-back controls. [1]=RegWrite, [0]=MemtoReg. Passed through.
- M_in  input  2  memory controls. [1]=MemRead, [0]=MemWrite.
- ALU_in  input  32  ALU result; byte address for loads and stores.
- RD2_in  input  32  store data.
- WN_in  input  5  destination register number.
- W_out  output  2  registered write-back controls.
- RD_out  output  32  registered load data.
- ALU_out  output  32  registered ALU result.
- WN_out  output  5  registered destination register.
- stall  output  1  combinational; high means upstream must hold the EX/MEM register and all earlier stages.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - W_out=0, RD_out=0, ALU_out=0, WN_out=0.
  - FSM=IDLE, counter=0, stall=0 while rst is high.
  - Data memory contents are not reset.
- Addressing: word index = ALU_in[$clog2(MEM_WORDS)+1:2]. ALU_in[1:0] is ignored. Upper bits are ignored, so out-of-range addresses wrap modulo MEM_WORDS.
- Memory op present when M_in != 0. M_in=2'b11 is illegal; it is treated as a write and RD_out captures 0.
- Non-memory op (M_in=0): stall=0. Next edge loads W/ALU/WN and RD_out=0. Latency is 1 cycle.
- FSM, states IDLE and BUSY; counter width $clog2(LATENCY)+1:
  - IDLE, op present, LATENCY>1: stall=1 this cycle. Next edge: BUSY, counter=LATENCY-2, and MEM/WB loads a bubble (W_out=0, RD_out, ALU_out and WN_out=0).
  - BUSY, counter>0: stall=1. Next edge: counter decrements and another bubble is loaded.
  - BUSY, counter==0 (final cycle): stall=0. Next edge: MEM/WB captures the instruction, the write commits, FSM returns to IDLE.
  - LATENCY==1: FSM stays in IDLE, stall never asserts, and the access completes at the first edge.
- Total occupancy of one memory op is exactly LATENCY cycles, with LATENCY-1 stall cycles.
- Upstream guarantees inputs are stable while stall=1. Inputs are sampled only on the completing edge.
- Write: memory[idx] <= RD2_in on the completing edge only.
- Read: RD_out <= memory[idx] (combinational array read) on the completing edge.
- Store followed immediately by a load to the same address: the load observes the new data, because the write commits before the load's completing edge.
- Back-to-back memory ops: an op arriving in IDLE directly after completion starts a new BUSY sequence; there is no idle gap.
- Reset mid-access: FSM goes to IDLE and outputs to 0. A pending write is aborted and memory is unchanged. stall drops in the reset cycle.
- W_in, WN_in and ALU_in pass through unmodified on completion. MemtoReg selection is done downstream.

Decomposition:
- Shared package pipe_pkg:
  - Bit-index constants: MEM_READ=1, MEM_WRITE=0, REG_WRITE=1, MEM_TO_REG=0.
  - FSM state enum {IDLE, BUSY}.
- One sub-module: data_memory.
  - Word array with combinational read and a synchronous write-enable port.
  - Parameterised by MEM_WORDS.
- FSM, counter and MEM/WB register stay in mem_wb_stage.

Test Plan:
- LATENCY=2, rst held 2 cycles -> all outputs 0 and stall=0, including while inputs are nonzero.
- ALU op: W_in=2'b10, M_in=0, ALU_in=0x0000_1234, WN_in=5 -> next cycle W_out=2'b10, ALU_out=0x1234, WN_out=5, RD_out=0; stall never asserted.
- Store then load, LATENCY=3:
  - Store: M_in=01, ALU_in=0x40, RD2_in=0xDEADBEEF -> stall high 2 cycles, 2 bubbles (W_out=0).
  - Load: M_in=10, W_in=11, ALU_in=0x40, WN_in=8 issued immediately after -> after 3 cycles RD_out=0xDEADBEEF, WN_out=8.
- Wrap and ignored low bits, MEM_WORDS=256:
  - Store 0xA5A5A5A5 to 0x403.
  - Load from 0x000 -> RD_out=0xA5A5A5A5.
- Reset mid-access, LATENCY=4:
  - Store 0x11111111 to 0x10, assert rst in the 2nd stall cycle -> stall=0, outputs 0.
  - A later load of 0x10 returns the prior contents (preloaded 0x22222222).
- LATENCY=1, alternating load/store/ALU ops each cycle -> stall constantly 0; every result appears exactly one cycle later; M_in=11 writes memory and RD_out=0.
